// File: rtl/mul_arbiter.sv
// Round-robin front end that shares one multi-cycle signed multiplier between
// N_REQ requesters and returns each product tagged with its owner's index.
//
// state   | meaning
// IDLE    | offer req_ready to the round-robin winner, latch its operands
// ISSUE   | pulse mul_start with the latched operands
// WAIT    | wait for mul_valid, watchdog counting
// CAPTURE | register mul_c and the owner id
// RESPOND | pulse rsp_valid
module mul_arbiter #(
  parameter  int WIDTH    = 10,
  parameter  int N_REQ    = 4,
  parameter  int WD_LIMIT = 8,
  localparam int IDW      = $clog2(N_REQ),
  localparam int OW       = WIDTH + 1,
  localparam int PW       = 2 * WIDTH + 2,
  localparam int CW       = $clog2(WD_LIMIT + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*OW-1:0] req_a_i,
  input  logic [N_REQ*OW-1:0] req_b_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [OW-1:0]       mul_a_o,
  output logic [OW-1:0]       mul_b_o,
  output logic                mul_start_o,
  input  logic                mul_valid_i,
  input  logic [PW-1:0]       mul_c_i,
  output logic                rsp_valid_o,
  output logic [PW-1:0]       rsp_data_o,
  output logic [IDW-1:0]      rsp_id_o,
  output logic                busy_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESPOND
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [OW-1:0]  a_q, a_d, b_q, b_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [PW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   scan;
  logic [OW-1:0]  win_a, win_b;

  // First valid requester at or after the pointer, wrapping at N_REQ.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    scan   = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(N_REQ)) scan = scan - (IDW+1)'(N_REQ);
      if (!found && req_valid_i[scan[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = scan[IDW-1:0];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == IDW'(k)) begin
        win_a = req_a_i[k*OW +: OW];
        win_b = req_b_i[k*OW +: OW];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          a_d     = win_a;
          b_d     = win_b;
          id_d    = win_id;
          ptr_d   = (win_id == IDW'(N_REQ-1)) ? '0 : win_id + IDW'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid_i) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == CW'(WD_LIMIT-1)) begin
          // Multiplier never answered: drop the op, no response.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CAPTURE: begin
        rsp_data_d = mul_c_i;
        rsp_id_d   = id_q;
        state_d    = S_RESPOND;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && found && !reset) req_ready_o[win_id] = 1'b1;
    mul_start_o = (state_q == S_ISSUE);
    rsp_valid_o = (state_q == S_RESPOND);
    busy_o      = (state_q != S_IDLE);
    mul_a_o     = a_q;
    mul_b_o     = b_q;
    rsp_data_o  = rsp_data_q;
    rsp_id_o    = rsp_id_q;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a behavioural multiplier stub that
// presents a garbage product on the valid cycle and the real one a cycle later.
module tb_mul_arbiter;

  logic        clock, reset;
  logic [3:0]  req_valid, req_ready;
  logic [43:0] req_a, req_b;
  logic [10:0] mul_a, mul_b;
  logic        mul_start, mul_valid;
  logic [21:0] mul_c, rsp_data;
  logic        rsp_valid, busy, err;
  logic [1:0]  rsp_id;

  logic               stub_en, st1, st2;
  logic signed [21:0] prod_q;

  int errs = 0;
  int checks = 0;

  mul_arbiter #(.WIDTH(10), .N_REQ(4), .WD_LIMIT(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_start_o(mul_start),
    .mul_valid_i(mul_valid), .mul_c_i(mul_c),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
    .busy_o(busy), .err_o(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      st1    <= 1'b0;
      st2    <= 1'b0;
      prod_q <= '0;
    end else begin
      st1 <= mul_start;
      st2 <= st1 & stub_en;
      if (mul_start) prod_q <= $signed(mul_a) * $signed(mul_b);
    end
  end
  assign mul_valid = st1 & stub_en;
  assign mul_c     = st2 ? prod_q : 22'h2AAAAA;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 in the following IDLE.
  task automatic do_op(input logic [3:0] mask, input int id, input int a,
                       input int b, input longint prod);
    req_a = '0;
    req_b = '0;
    req_a[id*11 +: 11] = a[10:0];
    req_b[id*11 +: 11] = b[10:0];
    req_valid = mask;
    #1;
    chk("ready", longint'(req_ready), longint'(1) << id);
    step();
    req_valid = '0;
    chk("issue_start", longint'(mul_start), 1);
    chk("issue_busy", longint'(busy), 1);
    chk("mul_a", longint'($signed(mul_a)), longint'(a));
    chk("mul_b", longint'($signed(mul_b)), longint'(b));
    step();
    chk("wait_start", longint'(mul_start), 0);
    chk("wait_busy", longint'(busy), 1);
    step();
    chk("capt_rsp_valid", longint'(rsp_valid), 0);
    chk("capt_busy", longint'(busy), 1);
    step();
    chk("rsp_valid", longint'(rsp_valid), 1);
    chk("rsp_data", longint'($signed(rsp_data)), prod);
    chk("rsp_id", longint'(rsp_id), longint'(id));
    chk("rsp_busy", longint'(busy), 1);
    step();
    chk("idle_rsp_valid", longint'(rsp_valid), 0);
    chk("idle_busy", longint'(busy), 0);
    chk("rsp_data_hold", longint'($signed(rsp_data)), prod);
  endtask

  initial begin
    int cnt;
    longint exp_f[4];
    exp_f = '{-10, -18, -28, -40};
    reset = 1'b1;
    stub_en = 1'b1;
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", longint'(req_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_start", longint'(mul_start), 0);
    req_valid = '0;
    reset = 1'b0;
    step();

    // single op, then extremes steering the pointer back to 0
    do_op(4'b0100, 2, 7, -3, -21);
    do_op(4'b0001, 0, -1024, -1024, 1048576);
    do_op(4'b1000, 3, -1024, 1023, -1047552);

    // fairness with all four held
    for (int k = 0; k < 4; k++) begin
      req_a[k*11 +: 11] = 11'(k + 2);
      req_b[k*11 +: 11] = 11'(-(k + 5));
    end
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("fair_ready", longint'(req_ready), longint'(1) << (g % 4));
      step();
      if (g == 4) req_valid = '0;
      step();
      step();
      step();
      chk("fair_rsp_valid", longint'(rsp_valid), 1);
      chk("fair_rsp_id", longint'(rsp_id), longint'(g % 4));
      chk("fair_rsp_data", longint'($signed(rsp_data)), exp_f[g % 4]);
      step();
    end

    // pointer wrap: p=3 with requesters 0 and 3
    do_op(4'b0100, 2, -1, -1, 1);
    do_op(4'b1001, 3, 13, -2, -26);
    do_op(4'b1001, 0, -13, -2, 26);

    // watchdog
    stub_en = 1'b0;
    req_a = '0;
    req_b = '0;
    req_a[1*11 +: 11] = 11'd5;
    req_b[1*11 +: 11] = 11'd5;
    req_valid = 4'b0010;
    #1;
    chk("wd_ready", longint'(req_ready), 2);
    step();
    req_valid = '0;
    cnt = 0;
    for (int c = 2; c <= 10; c++) begin
      step();
      if (rsp_valid) cnt++;
      if (c == 9) begin
        chk("wd_err_early", longint'(err), 0);
        chk("wd_busy_late", longint'(busy), 1);
      end
    end
    chk("wd_err", longint'(err), 1);
    chk("wd_idle", longint'(busy), 0);
    chk("wd_no_rsp", longint'(cnt), 0);
    stub_en = 1'b1;
    do_op(4'b0100, 2, 6, -7, -42);
    chk("wd_err_sticky", longint'(err), 1);

    // reset during WAIT
    stub_en = 1'b0;
    req_a = '0;
    req_b = '0;
    req_a[1*11 +: 11] = 11'd9;
    req_b[1*11 +: 11] = 11'd9;
    req_valid = 4'b0010;
    #1;
    chk("mid_ready", longint'(req_ready), 2);
    step();
    req_valid = '0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("mid_busy", longint'(busy), 0);
    chk("mid_mul_a", longint'(mul_a), 0);
    chk("mid_mul_b", longint'(mul_b), 0);
    chk("mid_rsp_data", longint'(rsp_data), 0);
    chk("mid_rsp_id", longint'(rsp_id), 0);
    chk("mid_err", longint'(err), 0);
    chk("mid_start", longint'(mul_start), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    stub_en = 1'b1;
    cnt = 0;
    repeat (6) begin
      step();
      if (rsp_valid) cnt++;
    end
    chk("mid_no_rsp", longint'(cnt), 0);
    do_op(4'b1010, 1, 11, 12, 132);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
